// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB (priority) and the MDU, and tracks
// registers whose MDU results are still in flight so ID can stall on RAW/WAW hazards.
module regfile_write_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_reg,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_we,
  input  logic [4:0]  id_rd,
  output logic        busy_stall,
  output logic        force_bubble,
  output logic        rf_we,
  output logic [4:0]  rf_reg,
  output logic [31:0] rf_data
);

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  logic        wb_act;
  logic        md_act;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] set_vec, clr_vec;

  assign wb_act = wb_we && (wb_reg != 5'd0);
  assign md_act = md_valid && (md_reg != 5'd0);

  // Fixed-priority grant; outputs are held at zero while reset is asserted.
  always_comb begin
    md_ready = 1'b0;
    rf_we    = 1'b0;
    rf_reg   = 5'd0;
    rf_data  = 32'd0;
    if (!rst) begin
      if (wb_act) begin
        rf_we   = 1'b1;
        rf_reg  = wb_reg;
        rf_data = wb_data;
      end else if (md_valid) begin
        // A result to r0 is accepted but never written.
        md_ready = 1'b1;
        rf_we    = md_act;
        rf_reg   = md_reg;
        rf_data  = md_data;
      end
    end
  end

  always_comb begin
    wait_cnt_d = 4'd0;
    if (md_valid && !md_ready) begin
      wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (md_issue) set_vec = 32'd1 << md_issue_reg;
    if (md_valid && md_ready) clr_vec = 32'd1 << md_reg;
    // Set applied after clear so a same-cycle reissue keeps the bit.
    pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      pending_q  <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    force_bubble = !rst && md_valid && (wait_cnt_q >= MaxWaitC);
    busy_stall   = !rst && (pending_q[id_rs] || pending_q[id_rt] ||
                            (id_we && pending_q[id_rd]) ||
                            (md_issue && pending_q[md_issue_reg]));
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: grant priority, starvation bubble,
// scoreboard RAW/WAW and r0 handling, with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_we;
  logic        busy_stall;
  logic        force_bubble;
  logic        rf_we;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_we        (wb_we),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .md_valid     (md_valid),
    .md_reg       (md_reg),
    .md_data      (md_data),
    .md_ready     (md_ready),
    .md_issue     (md_issue),
    .md_issue_reg (md_issue_reg),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_we        (id_we),
    .id_rd        (id_rd),
    .busy_stall   (busy_stall),
    .force_bubble (force_bubble),
    .rf_we        (rf_we),
    .rf_reg       (rf_reg),
    .rf_data      (rf_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next posedge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_reg = 0; wb_data = 0;
    md_valid = 0; md_reg = 0; md_data = 0;
    md_issue = 0; md_issue_reg = 0;
    id_rs = 0; id_rt = 0; id_we = 0; id_rd = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_md_ready", 32'(md_ready), 0);
    chk("rst_force_bubble", 32'(force_bubble), 0);
    chk("rst_busy", 32'(busy_stall), 0);
    chk("rst_rf_reg", 32'(rf_reg), 0);
    chk("rst_rf_data", rf_data, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset mid-wait clears the scoreboard and forces outputs
    md_issue = 1; md_issue_reg = 5'd12;
    next_cycle();
    md_issue = 0; id_rs = 5'd12;
    #1 chk("pre_rst_busy", 32'(busy_stall), 1);
    wb_we = 1; wb_reg = 5'd5; wb_data = 32'hDEAD_BEEF;
    md_valid = 1; md_reg = 5'd6; md_data = 32'h6;
    #1 chk("pre_rst_rf_we", 32'(rf_we), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_rf_we", 32'(rf_we), 0);
    chk("async_rst_md_ready", 32'(md_ready), 0);
    chk("async_rst_busy", 32'(busy_stall), 0);
    chk("async_rst_rf_data", rf_data, 0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    id_rs = 5'd12;
    #1 chk("post_rst_pending12", 32'(busy_stall), 0);
    id_rs = 0;

    // WB/MDU conflict: WB wins, MDU next cycle
    wb_we = 1; wb_reg = 5'd3; wb_data = 32'hAAAA_0000;
    md_valid = 1; md_reg = 5'd7; md_data = 32'h1234_5678;
    #1;
    chk("conf_wb_rf_we", 32'(rf_we), 1);
    chk("conf_wb_rf_reg", 32'(rf_reg), 3);
    chk("conf_wb_rf_data", rf_data, 32'hAAAA_0000);
    chk("conf_wb_md_ready", 32'(md_ready), 0);
    next_cycle();
    wb_we = 0;
    #1;
    chk("conf_md_rf_we", 32'(rf_we), 1);
    chk("conf_md_rf_reg", 32'(rf_reg), 7);
    chk("conf_md_rf_data", rf_data, 32'h1234_5678);
    chk("conf_md_ready", 32'(md_ready), 1);
    next_cycle();
    md_valid = 0;
    #1;
    chk("idle_rf_we", 32'(rf_we), 0);
    chk("idle_rf_reg", 32'(rf_reg), 0);
    chk("idle_rf_data", rf_data, 0);

    // Starvation: WB every cycle, MDU held; bubble from cycle 5
    wb_we = 1; wb_reg = 5'd1; wb_data = 32'h1;
    md_valid = 1; md_reg = 5'd8; md_data = 32'h55;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("starve_fb_c%0d", i), 32'(force_bubble), 0);
      chk($sformatf("starve_rdy_c%0d", i), 32'(md_ready), 0);
      next_cycle();
    end
    #1 chk("starve_fb_c5", 32'(force_bubble), 1);
    next_cycle();
    #1 chk("starve_fb_c6", 32'(force_bubble), 1);
    wb_we = 0;
    #1;
    chk("starve_grant_rdy", 32'(md_ready), 1);
    chk("starve_grant_reg", 32'(rf_reg), 8);
    next_cycle();
    // New result denied again: counter must have restarted from 0
    wb_we = 1; md_reg = 5'd10; md_data = 32'hA;
    #1 chk("starve_fb_cleared", 32'(force_bubble), 0);
    next_cycle();
    idle_inputs();

    // Scoreboard RAW on r9
    md_issue = 1; md_issue_reg = 5'd9; id_rs = 5'd9;
    #1 chk("raw_issue_cycle_busy", 32'(busy_stall), 0);
    next_cycle();
    md_issue = 0;
    #1 chk("raw_rs_busy", 32'(busy_stall), 1);
    id_rs = 0; id_rt = 5'd9;
    #1 chk("raw_rt_busy", 32'(busy_stall), 1);
    id_rt = 0; id_rs = 5'd9;
    next_cycle();
    md_valid = 1; md_reg = 5'd9; md_data = 32'h99;
    #1;
    chk("raw_accept_rdy", 32'(md_ready), 1);
    chk("raw_accept_busy", 32'(busy_stall), 1);
    next_cycle();
    md_valid = 0;
    #1 chk("raw_after_accept_busy", 32'(busy_stall), 0);
    idle_inputs();

    // WAW and set-wins on r4
    md_issue = 1; md_issue_reg = 5'd4;
    next_cycle();
    md_valid = 1; md_reg = 5'd4; md_data = 32'h44;
    #1 chk("waw_reissue_busy", 32'(busy_stall), 1);
    next_cycle();
    idle_inputs();
    id_we = 1; id_rd = 5'd4;
    #1 chk("waw_setwins_busy", 32'(busy_stall), 1);
    id_we = 0;
    #1 chk("waw_no_we_busy", 32'(busy_stall), 0);
    md_valid = 1; md_reg = 5'd4;
    next_cycle();
    md_valid = 0; id_we = 1;
    #1 chk("waw_cleared_busy", 32'(busy_stall), 0);
    idle_inputs();

    // r0 handling
    wb_we = 1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
    md_valid = 1; md_reg = 5'd0; md_data = 32'h77;
    #1;
    chk("r0_md_ready", 32'(md_ready), 1);
    chk("r0_rf_we", 32'(rf_we), 0);
    md_reg = 5'd5;
    #1;
    chk("wb_r0_md_grant_we", 32'(rf_we), 1);
    chk("wb_r0_md_grant_reg", 32'(rf_reg), 5);
    chk("wb_r0_md_grant_data", rf_data, 32'h77);
    next_cycle();
    idle_inputs();
    md_issue = 1; md_issue_reg = 5'd0;
    #1 chk("r0_issue_busy", 32'(busy_stall), 0);
    next_cycle();
    md_issue = 0;
    #1 chk("r0_after_issue_busy", 32'(busy_stall), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
